// File: rtl/gpr_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_queue
// Brief    : In-order writeback queue (ALU + load producers) feeding the GPR
//            file write port, with a youngest-match forwarding lookup.
// Revision : 1.0
// ============================================================================
module gpr_wb_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_dest,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     wb_stall,
  output logic                     reg_write_en,
  output logic [ADDR_W-1:0]        reg_write_dest,
  output logic [DATA_W-1:0]        reg_write_data,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  r_dest [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_not_full;
  logic               w_empty;
  logic               w_mem_acc;
  logic               w_alu_acc;
  logic               w_accept;
  logic               w_pop;
  logic [ADDR_W-1:0]  w_in_dest;
  logic [DATA_W-1:0]  w_in_data;
  logic               w_fwd_hit;
  logic [DATA_W-1:0]  w_fwd_data;

  // Readiness uses the pre-pop occupancy: a full queue refuses even while popping.
  assign w_not_full = (r_count < c_FULL);
  assign w_empty    = (r_count == '0);

  assign mem_ready  = w_not_full;
  assign alu_ready  = w_not_full && !mem_valid;

  assign w_mem_acc  = mem_valid && w_not_full;
  assign w_alu_acc  = alu_valid && w_not_full && !mem_valid;
  assign w_accept   = w_mem_acc || w_alu_acc;
  assign w_in_dest  = w_mem_acc ? mem_dest : alu_dest;
  assign w_in_data  = w_mem_acc ? mem_data : alu_data;

  assign w_pop          = !w_empty && !wb_stall;
  assign reg_write_en   = w_pop;
  assign reg_write_dest = w_empty ? '0 : r_dest[r_rd_ptr];
  assign reg_write_data = w_empty ? '0 : r_data[r_rd_ptr];

  assign count    = r_count;
  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_data;

  // Payload storage is never reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dest[r_wr_ptr] <= w_in_dest;
      r_data[r_wr_ptr] <= w_in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match wins; the entry being popped stays visible.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((c_CNT_W'(i) < r_count) &&
          (r_dest[r_rd_ptr + c_PTR_W'(i)] == fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[r_rd_ptr + c_PTR_W'(i)];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb_queue
// Brief    : Directed + randomized bench for gpr_wb_queue against a queue model.
// Revision : 1.0
// ============================================================================
module tb_gpr_wb_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0]  dest;
    logic [15:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [2:0]  alu_dest, mem_dest, reg_write_dest, fwd_addr;
  logic [15:0] alu_data, mem_data, reg_write_data, fwd_data;
  logic        wb_stall, reg_write_en, fwd_hit;
  logic [2:0]  count;

  gpr_wb_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .wb_stall(wb_stall), .reg_write_en(reg_write_en),
    .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_writes = 0;
  logic o_ar, o_mr, o_we, o_hit;
  logic [2:0] o_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, compare outputs against the model, then advance both.
  task automatic cycle(input logic av, input logic [2:0] ad, input logic [15:0] adt,
                       input logic mv, input logic [2:0] md, input logic [15:0] mdt,
                       input logic st, input logic [2:0] fa,
                       output bit a_acc, output bit m_acc);
    logic        e_mr, e_ar, e_we, e_hit;
    logic [2:0]  e_wd;
    logic [15:0] e_wdt, e_fd;
    ent_t        ne;
    alu_valid = av; alu_dest = ad; alu_data = adt;
    mem_valid = mv; mem_dest = md; mem_data = mdt;
    wb_stall  = st; fwd_addr = fa;
    #2;
    e_mr  = (q.size() < DEPTH);
    e_ar  = e_mr && !mv;
    e_we  = (q.size() != 0) && !st;
    e_wd  = (q.size() != 0) ? q[0].dest : 3'd0;
    e_wdt = (q.size() != 0) ? q[0].data : 16'd0;
    e_hit = 1'b0;
    e_fd  = 16'd0;
    foreach (q[i]) if (q[i].dest == fa) begin e_hit = 1'b1; e_fd = q[i].data; end
    check("mem_ready", 32'(mem_ready), 32'(e_mr));
    check("alu_ready", 32'(alu_ready), 32'(e_ar));
    check("reg_write_en", 32'(reg_write_en), 32'(e_we));
    check("reg_write_dest", 32'(reg_write_dest), 32'(e_wd));
    check("reg_write_data", 32'(reg_write_data), 32'(e_wdt));
    check("fwd_hit", 32'(fwd_hit), 32'(e_hit));
    check("fwd_data", 32'(fwd_data), 32'(e_fd));
    check("count", 32'(count), q.size());
    o_ar = alu_ready; o_mr = mem_ready; o_we = reg_write_en; o_hit = fwd_hit; o_cnt = count;
    if (reg_write_en === 1'b1) n_writes++;
    m_acc = mv && e_mr;
    a_acc = av && e_ar;
    ne.dest = m_acc ? md : ad;
    ne.data = m_acc ? mdt : adt;
    @(posedge clk);
    #1;
    if (e_we) void'(q.pop_front());
    if (m_acc || a_acc) q.push_back(ne);
  endtask

  task automatic idle(input logic st, input int n);
    bit aa, ma;
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, st, 3'd0, aa, ma);
  endtask

  initial begin
    bit aa, ma;
    int sent, tries;
    bit st;
    bit a_pend, m_pend;
    logic [2:0]  rad, rmd, rfa;
    logic [15:0] radt, rmdt;

    reset = 1'b0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
    wb_stall = 0; fwd_addr = 0;
    #3;
    check("rst_count", 32'(count), 0);
    check("rst_alu_ready", 32'(alu_ready), 1);
    check("rst_mem_ready", 32'(mem_ready), 1);
    check("rst_we", 32'(reg_write_en), 0);
    check("rst_dest", 32'(reg_write_dest), 0);
    check("rst_data", 32'(reg_write_data), 0);
    check("rst_fwd_hit", 32'(fwd_hit), 0);
    check("rst_fwd_data", 32'(fwd_data), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single ALU write
    cycle(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, aa, ma);
    check("t1_alu_ready", 32'(o_ar), 1);
    check("t1_we", 32'(reg_write_en), 1);
    check("t1_dest", 32'(reg_write_dest), 3);
    check("t1_data", 32'(reg_write_data), 32'hBEEF);
    idle(1'b0, 1);
    check("t1_count", 32'(count), 0);

    // Simultaneous producers: load first
    cycle(1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022, 1'b0, 3'd0, aa, ma);
    check("t2_alu_blocked", 32'(o_ar), 0);
    check("t2_head_dest", 32'(reg_write_dest), 2);
    check("t2_head_data", 32'(reg_write_data), 32'h0022);
    cycle(1'b1, 3'd1, 16'h0011, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, aa, ma);
    check("t2_alu_acc", 32'(o_ar), 1);
    check("t2_head2_dest", 32'(reg_write_dest), 1);
    check("t2_head2_data", 32'(reg_write_data), 32'h0011);
    idle(1'b0, 2);

    // Fill under stall
    for (int k = 1; k <= 5; k++)
      cycle(1'b1, 3'd4, 16'(k), 1'b0, 3'd0, 16'd0, 1'b1, 3'd0, aa, ma);
    check("t3_full_refuse", 32'(o_ar), 0);
    check("t3_full_count", 32'(o_cnt), 4);
    tries = 0;
    do begin
      cycle(1'b1, 3'd4, 16'd5, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, aa, ma);
      tries++;
    end while (!aa && tries < 10);
    check("t3_fifth_latency", tries, 2);
    idle(1'b0, 6);

    // Forwarding youngest match
    cycle(1'b1, 3'd5, 16'h1111, 1'b0, 3'd0, 16'd0, 1'b1, 3'd0, aa, ma);
    cycle(1'b1, 3'd5, 16'h2222, 1'b0, 3'd0, 16'd0, 1'b1, 3'd0, aa, ma);
    cycle(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1, 3'd5, aa, ma);
    check("t4_hit5", 32'(o_hit), 1);
    check("t4_data5", 32'(fwd_data), 32'h2222);
    cycle(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1, 3'd6, aa, ma);
    check("t4_hit6", 32'(o_hit), 0);
    check("t4_data6", 32'(fwd_data), 0);
    idle(1'b0, 4);

    // Pointer wrap with toggling stall
    sent = 0; st = 1'b0; n_writes = 0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0 && c % 3 == 0) st = !st;
      cycle(sent < 10, (sent % 2 != 0) ? 3'd6 : 3'd7, 16'h0A00 + 16'(sent),
            1'b0, 3'd0, 16'd0, st, 3'd6, aa, ma);
      if (aa) sent++;
    end
    idle(1'b0, 8);
    check("t5_sent", sent, 10);
    check("t5_writes", n_writes, 10);

    // Asynchronous reset mid-stall
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 3'd2, 16'h0C00 + 16'(k), 1'b0, 3'd0, 16'd0, 1'b1, 3'd2, aa, ma);
    alu_valid = 1'b0;
    #3;
    check("t6_pre_count", 32'(count), 3);
    reset = 1'b0;
    #1;
    check("t6_count", 32'(count), 0);
    check("t6_we", 32'(reg_write_en), 0);
    check("t6_alu_ready", 32'(alu_ready), 1);
    check("t6_mem_ready", 32'(mem_ready), 1);
    check("t6_fwd_hit", 32'(fwd_hit), 0);
    q.delete();
    @(posedge clk); #2;
    reset = 1'b1;
    n_writes = 0;
    idle(1'b0, 5);
    check("t6_no_stale_writes", n_writes, 0);

    // Randomized traffic with stable-until-accepted producers
    a_pend = 0; m_pend = 0;
    rad = 0; rmd = 0; radt = 0; rmdt = 0;
    for (int c = 0; c < 400; c++) begin
      if (!a_pend && $urandom_range(0, 99) < 60) begin
        a_pend = 1; rad = 3'($urandom); radt = 16'($urandom);
      end
      if (!m_pend && $urandom_range(0, 99) < 35) begin
        m_pend = 1; rmd = 3'($urandom); rmdt = 16'($urandom);
      end
      st  = ($urandom_range(0, 99) < 30);
      rfa = 3'($urandom);
      cycle(a_pend, rad, radt, m_pend, rmd, rmdt, st, rfa, aa, ma);
      if (aa) a_pend = 0;
      if (ma) m_pend = 0;
    end
    idle(1'b0, 6);
    check("final_empty", 32'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
